// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver: HUB75 LED-matrix scan engine with binary-coded-modulation.
// Fetches one column per 3 cycles from the framebuffer, shifts it into both
// panel halves, latches the row, then holds nOE low for a plane-weighted time.
// Optional feature macro: HUB75_BCM_EN (multi-plane BCM). When undefined only
// the MSB plane is shown, every SHOW lasts SHOW_BASE cycles.
// Output pipeline: rd_en/LATCH/nOE/row_addr are decoded from the next state so
// they are valid during the state itself; colour data is captured from the
// framebuffer at the end of SHIFT_LO, and S_CLK rises one cycle later, so the
// data never moves on an S_CLK edge.
module hub75_scan_driver #(
  parameter int COLS      = 64,
  parameter int SCAN_ROWS = 32,
  parameter int ROW_W     = 5,
  parameter int COL_W     = 6,
  parameter int PLANES    = 4,
  parameter int SHOW_BASE = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  output logic                  rd_en,
  output logic [ROW_W-1:0]      rd_row,
  output logic [COL_W-1:0]      rd_col,
  input  logic [3*PLANES-1:0]   rd_rgb0,
  input  logic [3*PLANES-1:0]   rd_rgb1,
  output logic                  R0,
  output logic                  G0,
  output logic                  B0,
  output logic                  R1,
  output logic                  G1,
  output logic                  B1,
  output logic [ROW_W-1:0]      row_addr,
  output logic                  S_CLK,
  output logic                  LATCH,
  output logic                  nOE,
  output logic                  frame_done
);

  localparam int PL_W  = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int CNT_W = PLANES - 1 + $clog2(SHOW_BASE + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, SHIFT_LO, SHIFT_HI, BLANK, LAT, SHOW, NEXT
  } state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PL_W-1:0]  plane_s;
  logic [CNT_W-1:0] show_len_s;
  logic             plane_last_s;
  logic             row_last_s;
  logic             wrap_s;

  logic             rd_en_q, s_clk_q, latch_q, noe_q, frame_done_q;
  logic [ROW_W-1:0] rd_row_q, row_addr_q;
  logic [COL_W-1:0] rd_col_q;
  logic [5:0]       rgb_q;

`ifdef HUB75_BCM_EN
  logic [PL_W-1:0]  plane_q, plane_d;
  assign plane_s      = plane_q;
  assign plane_last_s = (plane_q == PL_W'(PLANES - 1));
  assign show_len_s   = CNT_W'(SHOW_BASE) << plane_s;
`else
  assign plane_s      = PL_W'(PLANES - 1);
  assign plane_last_s = 1'b1;
  assign show_len_s   = CNT_W'(SHOW_BASE);
`endif

  assign row_last_s = (row_q == ROW_W'(SCAN_ROWS - 1));
  assign wrap_s     = plane_last_s && row_last_s;

  // Select bit `pl` of colour channel `ch` (0=R, 1=G, 2=B) from a packed pixel.
  function automatic logic pick_bit(input logic [3*PLANES-1:0] px,
                                    input int unsigned ch,
                                    input logic [PL_W-1:0] pl);
    logic [3*PLANES-1:0] sh;
    sh = px >> (ch * 32'(PLANES) + 32'(pl));
    return sh[0];
  endfunction

  // State and scan-position registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
`ifdef HUB75_BCM_EN
      plane_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
`ifdef HUB75_BCM_EN
      plane_q <= plane_d;
`endif
    end
  end

  // Next-state and scan-position update.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
`ifdef HUB75_BCM_EN
    plane_d = plane_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable) state_d = FETCH;
        else        state_d = IDLE;
      end
      FETCH:    state_d = SHIFT_LO;
      SHIFT_LO: state_d = SHIFT_HI;
      SHIFT_HI: begin
        if (col_q == COL_W'(COLS - 1)) begin
          col_d   = '0;
          state_d = BLANK;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = FETCH;
        end
      end
      BLANK: state_d = LAT;
      LAT: begin
        cnt_d   = show_len_s;
        state_d = SHOW;
      end
      SHOW: begin
        if (cnt_q == CNT_W'(1)) state_d = NEXT;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      NEXT: begin
        if (plane_last_s) begin
`ifdef HUB75_BCM_EN
          plane_d = '0;
`endif
          if (row_last_s) row_d = '0;
          else            row_d = row_q + 1'b1;
        end else begin
`ifdef HUB75_BCM_EN
          plane_d = plane_q + 1'b1;
`endif
        end
        if (wrap_s && !enable) state_d = IDLE;
        else                   state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered panel and framebuffer outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_en_q      <= 1'b0;
      rd_row_q     <= '0;
      rd_col_q     <= '0;
      rgb_q        <= 6'd0;
      s_clk_q      <= 1'b0;
      latch_q      <= 1'b0;
      noe_q        <= 1'b1;
      row_addr_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      rd_en_q      <= (state_d == FETCH);
      if (state_d == FETCH) begin
        rd_row_q <= row_d;
        rd_col_q <= col_d;
      end
      if (state_q == SHIFT_LO) begin
        rgb_q <= {pick_bit(rd_rgb0, 32'd0, plane_s), pick_bit(rd_rgb0, 32'd1, plane_s),
                  pick_bit(rd_rgb0, 32'd2, plane_s), pick_bit(rd_rgb1, 32'd0, plane_s),
                  pick_bit(rd_rgb1, 32'd1, plane_s), pick_bit(rd_rgb1, 32'd2, plane_s)};
      end
      s_clk_q      <= (state_q == SHIFT_HI);
      latch_q      <= (state_d == LAT);
      noe_q        <= (state_d != SHOW);
      if (state_d == LAT) row_addr_q <= row_q;
      frame_done_q <= (state_d == NEXT) && wrap_s;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_row     = rd_row_q;
  assign rd_col     = rd_col_q;
  assign {R0, G0, B0, R1, G1, B1} = rgb_q;
  assign row_addr   = row_addr_q;
  assign S_CLK      = s_clk_q;
  assign LATCH      = latch_q;
  assign nOE        = noe_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver on a 4-column, 2-row, 2-plane panel.
module tb_hub75_scan_driver;
  localparam int COLS = 4;
  localparam int SCAN_ROWS = 2;
  localparam int PLANES = 2;
  localparam int SHOW_BASE = 2;
`ifdef HUB75_BCM_EN
  localparam bit BCM = 1'b1;
  localparam int FRAME_LEN = 72;
`else
  localparam bit BCM = 1'b0;
  localparam int FRAME_LEN = 34;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic       rd_en;
  logic [0:0] rd_row;
  logic [1:0] rd_col;
  logic [5:0] rd_rgb0 = 6'd0;
  logic [5:0] rd_rgb1 = 6'd0;
  logic       R0, G0, B0, R1, G1, B1;
  logic [0:0] row_addr;
  logic       S_CLK, LATCH, nOE, frame_done;

  int n_total = 0;
  int n_bad = 0;

  logic [5:0] mem0 [0:7];
  logic [5:0] mem1 [0:7];

  int cyc, exp_row, exp_plane, exp_k, exp_fc, rp_start, run;
  logic prev_sclk, prev_noe;
  logic [0:0] prev_ra;

  hub75_scan_driver #(
    .COLS(COLS), .SCAN_ROWS(SCAN_ROWS), .ROW_W(1), .COL_W(2),
    .PLANES(PLANES), .SHOW_BASE(SHOW_BASE)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
    .rd_rgb0(rd_rgb0), .rd_rgb1(rd_rgb1),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .row_addr(row_addr), .S_CLK(S_CLK), .LATCH(LATCH), .nOE(nOE),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Framebuffer read port: one-cycle registered read.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_rgb0 <= mem0[{rd_row, rd_col}];
      rd_rgb1 <= mem1[{rd_row, rd_col}];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic bitof(input logic [5:0] v, input int i);
    logic [5:0] s;
    s = v >> i;
    return s[0];
  endfunction

  // Expected {R0,G0,B0,R1,G1,B1} for a row/column/plane; pixel format {B,G,R}.
  function automatic logic [5:0] exp_px(input int r, input int c, input int p);
    logic [5:0] a, b;
    a = mem0[3'(r * COLS + c)];
    b = mem1[3'(r * COLS + c)];
    return {bitof(a, p), bitof(a, p + 2), bitof(a, p + 4),
            bitof(b, p), bitof(b, p + 2), bitof(b, p + 4)};
  endfunction

  task automatic mon();
    int show;
    bit wrap;
    if (rd_en) begin
      check_eq("rd_col", 32'(rd_col), 32'(exp_fc));
      check_eq("rd_row", 32'(rd_row), 32'(exp_row));
      if (exp_fc == 0) rp_start = cyc;
      exp_fc = (exp_fc + 1) % COLS;
    end
    if (S_CLK && !prev_sclk) begin
      check_eq("sclk_noe", 32'(nOE), 32'd1);
      check_eq("pixel", 32'({R0, G0, B0, R1, G1, B1}), 32'(exp_px(exp_row, exp_k, exp_plane)));
      exp_k++;
    end
    if (LATCH) begin
      check_eq("latch_noe", 32'(nOE), 32'd1);
      check_eq("row_addr", 32'(row_addr), 32'(exp_row));
      check_eq("shift_cnt", 32'(exp_k), 32'(COLS));
    end
    if (row_addr !== prev_ra) check_eq("ra_change_latch", 32'(LATCH), 32'd1);
    if (!nOE) run++;
    if (nOE && !prev_noe) begin
      show = BCM ? (SHOW_BASE << exp_plane) : SHOW_BASE;
      check_eq("show_len", 32'(run), 32'(show));
      check_eq("rp_len", 32'(cyc - rp_start), 32'(3 * COLS + 2 + show));
      wrap = (exp_row == SCAN_ROWS - 1) && (!BCM || exp_plane == PLANES - 1);
      check_eq("frame_done", 32'(frame_done), 32'(wrap));
      if (BCM && exp_plane != PLANES - 1) begin
        exp_plane++;
      end else begin
        if (BCM) exp_plane = 0;
        exp_row = (exp_row + 1) % SCAN_ROWS;
      end
      run = 0;
      exp_k = 0;
    end else if (frame_done) begin
      check_eq("fd_spurious", 32'(frame_done), 32'd0);
    end
    prev_sclk = S_CLK;
    prev_noe = nOE;
    prev_ra = row_addr;
  endtask

  // Monitors one frame starting at the sample of its first FETCH cycle.
  task automatic run_frame(input int drop_at);
    bit done;
    cyc = 0; exp_row = 0; exp_plane = BCM ? 0 : PLANES - 1;
    exp_k = 0; exp_fc = 0; rp_start = 0; run = 0;
    prev_sclk = 1'b0; prev_noe = 1'b1; prev_ra = row_addr;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      cyc = i;
      if (i == drop_at) enable = 1'b0;
      mon();
      if (frame_done) begin
        done = 1'b1;
        check_eq("frame_len", 32'(cyc), 32'(FRAME_LEN - 1));
      end else begin
        @(negedge clk);
      end
    end
    check_eq("frame_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;
    mem0[0] = 6'b11_01_10; mem0[1] = 6'b00_10_01; mem0[2] = 6'b10_11_00; mem0[3] = 6'b01_00_11;
    mem0[4] = 6'b10_01_01; mem0[5] = 6'b01_10_10; mem0[6] = 6'b11_10_00; mem0[7] = 6'b00_01_11;
    mem1[0] = 6'b00_01_11; mem1[1] = 6'b11_10_00; mem1[2] = 6'b01_01_01; mem1[3] = 6'b10_10_10;
    mem1[4] = 6'b00_11_00; mem1[5] = 6'b11_00_11; mem1[6] = 6'b10_00_01; mem1[7] = 6'b01_11_10;

    resetn = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_vals", 32'({nOE, LATCH, S_CLK, rd_en, frame_done, R0, G0, B0, R1, G1, B1,
                                row_addr, rd_row, rd_col}), 32'({1'b1, 14'd0}));
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_rd_en", 32'(rd_en), 32'd0);
    check_eq("idle_noe", 32'(nOE), 32'd1);

    // Frame 1: first rd_en the cycle after IDLE sees enable.
    enable = 1'b1;
    @(negedge clk);
    check_eq("first_rd_en", 32'(rd_en), 32'd1);
    run_frame(-1);

    // Frame 2: enable drops during row 0, frame still completes.
    @(negedge clk);
    run_frame(5);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (nOE !== 1'b1 || rd_en !== 1'b0 || S_CLK !== 1'b0) viol++;
    end
    check_eq("idle_after_drop", 32'(viol), 32'd0);

    // Frame 3: re-raise restarts at row 0, plane 0.
    enable = 1'b1;
    @(negedge clk);
    check_eq("restart_rd_en", 32'(rd_en), 32'd1);
    run_frame(-1);

    // Async reset in SHIFT_HI of column 1 of the next frame.
    repeat (4) @(negedge clk);
    check_eq("sclk_pre_rst", 32'(S_CLK), 32'd1);
    check_eq("ra_pre_rst", 32'(row_addr), 32'd1);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_async", 32'({nOE, LATCH, S_CLK, rd_en, frame_done, R0, G0, B0, R1, G1, B1,
                               row_addr, rd_row, rd_col}), 32'({1'b1, 14'd0}));
    check_eq("rst_sclk", 32'(S_CLK), 32'd0);
    check_eq("rst_row_addr", 32'(row_addr), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_eq("post_rst_rd_en", 32'(rd_en), 32'd1);
    run_frame(-1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
